// File: rtl/hostio_mmio_bridge_if.sv
// Bus and host-stream signals of the multi-channel MMIO byte-stream bridge.
// master = yarvi bus plus host comm side, slave = the bridge.
interface hostio_mmio_bridge_if #(
    parameter int unsigned CHANNELS = 1
);
    logic [29:0]             address;
    logic                    writeenable;
    logic [31:0]             writedata;
    logic [3:0]              byteena;
    logic                    readenable;
    logic [31:0]             readdata;

    logic [CHANNELS-1:0]     host_rx_valid;
    logic [8*CHANNELS-1:0]   host_rx_data;
    logic [CHANNELS-1:0]     host_rx_ready;
    logic [CHANNELS-1:0]     host_tx_valid;
    logic [8*CHANNELS-1:0]   host_tx_data;
    logic [CHANNELS-1:0]     host_tx_ready;
    logic [CHANNELS-1:0]     irq;

    modport master (
        output address, writeenable, writedata, byteena, readenable,
        input  readdata,
        output host_rx_valid, host_rx_data,
        input  host_rx_ready,
        input  host_tx_valid, host_tx_data,
        output host_tx_ready,
        input  irq
    );

    modport slave (
        input  address, writeenable, writedata, byteena, readenable,
        output readdata,
        input  host_rx_valid, host_rx_data,
        output host_rx_ready,
        output host_tx_valid, host_tx_data,
        input  host_tx_ready,
        output irq
    );
endinterface

// File: rtl/hostio_mmio_bridge.sv
// Multi-channel memory-mapped byte-stream bridge between the yarvi data bus and
// host-link streams: per-channel RX/TX FIFOs, counts, sticky overflow, flush, irq.
module hostio_mmio_bridge #(
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned IO_BIT     = 29
) (
    input  logic                clk,
    input  logic                reset,
    hostio_mmio_bridge_if.slave bus
);
    localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_COUNT  = 2'd2,
        REG_CTRL   = 2'd3
    } reg_e;

    logic [7:0]          rx_mem [CHANNELS][DEPTH];
    logic [7:0]          tx_mem [CHANNELS][DEPTH];
    logic [PW-1:0]       rx_wp  [CHANNELS];
    logic [PW-1:0]       rx_rp  [CHANNELS];
    logic [PW-1:0]       tx_wp  [CHANNELS];
    logic [PW-1:0]       tx_rp  [CHANNELS];
    logic [CHANNELS-1:0] tx_ovf, rx_ie, tx_ie, irq_q;
    logic [31:0]         readdata_q;

    reg_e                reg_sel;
    logic [CW-1:0]       ch_sel;
    logic                io_hit;

    logic [CHANNELS-1:0] rx_empty, rx_full, tx_empty, tx_full;
    logic [CHANNELS-1:0] ch_hit, data_acc, rx_push, rx_pop, tx_push, tx_pop, tx_drop;
    logic [CHANNELS-1:0] ctrl_wr, ovf_clr;
    logic [PW-1:0]       rx_cnt  [CHANNELS];
    logic [PW-1:0]       tx_cnt  [CHANNELS];
    logic [7:0]          rx_head [CHANNELS];
    logic [8*CHANNELS-1:0] tx_data_v;
    logic [31:0]         rd_next;

    assign reg_sel = reg_e'(bus.address[1:0]);
    assign ch_sel  = bus.address[2 +: CW];
    assign io_hit  = bus.address[IO_BIT] && (32'(ch_sel) < CHANNELS);

    always_comb begin
        rx_empty  = '0;
        rx_full   = '0;
        tx_empty  = '0;
        tx_full   = '0;
        ch_hit    = '0;
        data_acc  = '0;
        rx_push   = '0;
        rx_pop    = '0;
        tx_push   = '0;
        tx_pop    = '0;
        tx_drop   = '0;
        ctrl_wr   = '0;
        ovf_clr   = '0;
        tx_data_v = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            rx_empty[c] = (rx_wp[c] == rx_rp[c]);
            tx_empty[c] = (tx_wp[c] == tx_rp[c]);
            // Full: wrap bits differ while the index bits match.
            rx_full[c]  = (rx_wp[c][PW-1] != rx_rp[c][PW-1]) &&
                          (rx_wp[c][PW-2:0] == rx_rp[c][PW-2:0]);
            tx_full[c]  = (tx_wp[c][PW-1] != tx_rp[c][PW-1]) &&
                          (tx_wp[c][PW-2:0] == tx_rp[c][PW-2:0]);
            rx_cnt[c]   = rx_wp[c] - rx_rp[c];
            tx_cnt[c]   = tx_wp[c] - tx_rp[c];
            rx_head[c]  = rx_empty[c] ? 8'd0 : rx_mem[c][rx_rp[c][PW-2:0]];
            tx_data_v[8*c +: 8] = tx_mem[c][tx_rp[c][PW-2:0]];

            ch_hit[c]   = io_hit && (32'(ch_sel) == c);
            data_acc[c] = ch_hit[c] && (reg_sel == REG_DATA) && bus.byteena[0];
            rx_pop[c]   = data_acc[c] && bus.readenable && !rx_empty[c];
            tx_push[c]  = data_acc[c] && bus.writeenable && !tx_full[c];
            tx_drop[c]  = data_acc[c] && bus.writeenable && tx_full[c];
            rx_push[c]  = bus.host_rx_valid[c] && !rx_full[c];
            tx_pop[c]   = bus.host_tx_ready[c] && !tx_empty[c];
            ctrl_wr[c]  = ch_hit[c] && bus.writeenable && (reg_sel == REG_CTRL);
            ovf_clr[c]  = ch_hit[c] && bus.writeenable && (reg_sel == REG_STATUS) &&
                          bus.writedata[2];
        end
    end

    always_comb begin
        rd_next = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_hit[c]) begin
                case (reg_sel)
                    REG_DATA:   rd_next = {15'd0, !rx_empty[c], !rx_empty[c], 7'd0, rx_head[c]};
                    REG_STATUS: rd_next = {15'd0, !tx_full[c], 11'd0, rx_ie[c], tx_ie[c],
                                           tx_ovf[c], rx_full[c], !rx_empty[c]};
                    REG_COUNT:  rd_next = {16'(rx_cnt[c]), 16'(tx_cnt[c])};
                    REG_CTRL:   rd_next = {28'd0, tx_ie[c], rx_ie[c], 2'b00};
                    default:    rd_next = '0;
                endcase
            end
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (rx_push[c]) rx_mem[c][rx_wp[c][PW-2:0]] <= bus.host_rx_data[8*c +: 8];
            if (tx_push[c]) tx_mem[c][tx_wp[c][PW-2:0]] <= bus.writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
            tx_ovf     <= '0;
            rx_ie      <= '0;
            tx_ie      <= '0;
            irq_q      <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                rx_wp[c] <= '0;
                rx_rp[c] <= '0;
                tx_wp[c] <= '0;
                tx_rp[c] <= '0;
            end
        end else begin
            if (bus.readenable) readdata_q <= rd_next;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (ctrl_wr[c] && bus.writedata[0]) begin
                    rx_wp[c] <= '0;
                    rx_rp[c] <= '0;
                end else begin
                    if (rx_push[c]) rx_wp[c] <= rx_wp[c] + PW'(1);
                    if (rx_pop[c])  rx_rp[c] <= rx_rp[c] + PW'(1);
                end
                if (ctrl_wr[c] && bus.writedata[1]) begin
                    tx_wp[c] <= '0;
                    tx_rp[c] <= '0;
                end else begin
                    if (tx_push[c]) tx_wp[c] <= tx_wp[c] + PW'(1);
                    if (tx_pop[c])  tx_rp[c] <= tx_rp[c] + PW'(1);
                end
                if (ctrl_wr[c]) begin
                    rx_ie[c] <= bus.writedata[2];
                    tx_ie[c] <= bus.writedata[3];
                end
                if (tx_drop[c])      tx_ovf[c] <= 1'b1;
                else if (ovf_clr[c]) tx_ovf[c] <= 1'b0;
                irq_q[c] <= (rx_ie[c] && !rx_empty[c]) || (tx_ie[c] && tx_empty[c]);
            end
        end
    end

    assign bus.readdata      = readdata_q;
    assign bus.irq           = irq_q;
    assign bus.host_rx_ready = ~rx_full;
    assign bus.host_tx_valid = ~tx_empty;
    assign bus.host_tx_data  = tx_data_v;
endmodule
